// File: rtl/i2s_audio_tx.sv
// I2S audio transmitter: 16-bit stereo, codec clocks derived from one frame counter.
// Latency: samples latched at the frame's last cycle appear from the left MSB of the next frame.
// Backpressure: none; inputs are sampled only in the sample_ack cycle.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   sample_l/r   16-bit left/right samples (offset-binary or two's complement, see SIGNED_IN)
//   mute         latch silence instead of the inputs at the latch cycle
//   sample_ack   one-cycle pulse in the cycle the inputs are latched
//   aud_xck      codec master clock (clk/2)
//   aud_bclk     bit clock, low in first half of each bit slot
//   aud_daclrck  word select, low = left, high = right
//   aud_dacdat   serial data, MSB first, one-bit I2S delay
module i2s_audio_tx #(
  parameter int CLK_PER_BIT = 8,
  parameter int SIGNED_IN   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        mute,
  output logic        sample_ack,
  output logic        aud_xck,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_dacdat
);

  localparam int PW = $clog2(CLK_PER_BIT);
  localparam int CW = PW + 5;
  // Offset-binary to two's complement is a flip of the sign bit.
  localparam logic [15:0] FLIP = (SIGNED_IN == 0) ? 16'h8000 : 16'h0000;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   hold_l_q, hold_l_d;
  logic [15:0]   hold_r_q, hold_r_d;
  logic          dacdat_q, dacdat_d;

  logic          phase_end;
  logic          latch;
  logic [3:0]    slot;
  logic          chan;

  assign phase_end = &cnt_q[PW-1:0];
  assign latch     = &cnt_q;
  assign slot      = cnt_q[PW+3:PW];
  assign chan      = cnt_q[CW-1];

  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    dacdat_d = dacdat_q;

    if (latch) begin
      if (mute) begin
        hold_l_d = 16'h0000;
        hold_r_d = 16'h0000;
      end else begin
        hold_l_d = sample_l ^ FLIP;
        hold_r_d = sample_r ^ FLIP;
      end
    end

    // Loading at the last phase of slot s puts bit (15-s) on the wire for
    // slot s+1: this gives the one-bit I2S delay. At the all-ones count the
    // right LSB is taken from the old hold value, before the latch lands.
    if (phase_end) begin
      dacdat_d = chan ? hold_r_q[~slot] : hold_l_q[~slot];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      dacdat_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      dacdat_q <= dacdat_d;
    end
  end

  // Gated by reset so a reset landing on the all-ones count does not
  // announce a latch that never happens.
  assign sample_ack  = latch & ~reset;
  assign aud_xck     = cnt_q[0];
  assign aud_bclk    = cnt_q[PW-1];
  assign aud_daclrck = cnt_q[CW-1];
  assign aud_dacdat  = dacdat_q;

endmodule
